// File: rtl/snn_result_collector_if.sv
// Result stream between the SNN result collector and its downstream consumer.
// The collector presents the FIFO head; the consumer acknowledges with res_ready.
interface snn_result_collector_if #(
    parameter int CNT_W = 16
);
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_class;
    logic             res_no_spike;
    logic             res_timeout;
    logic [CNT_W-1:0] res_index;

    modport master (
        output res_valid, res_class, res_no_spike, res_timeout, res_index,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_class, res_no_spike, res_timeout, res_index,
        output res_ready
    );
endinterface

// File: rtl/snn_result_collector.sv
// SNN result collector: launches one classifier inference at a time, guards it
// with a watchdog, queues each result in a small fall-through FIFO and keeps
// saturating per-class histogram counters with a registered readout.
module snn_result_collector #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    output logic                   start_process,
    input  logic                   end_process,
    input  logic [1:0]             output_class,
    input  logic                   no_spike,
    snn_result_collector_if.master res,
    input  logic [2:0]             cnt_sel,
    output logic [CNT_W-1:0]       cnt_data,
    input  logic                   cnt_clear,
    output logic                   busy,
    output logic                   err_spurious
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int WD_W    = $clog2(TIMEOUT + 1);
    localparam int ENTRY_W = CNT_W + 4;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [PTR_W:0]   FULL_N  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [2:0] CNT_NS   = 3'd4;
    localparam logic [2:0] CNT_TO   = 3'd5;
    localparam logic [2:0] CNT_TOT  = 3'd6;
    localparam logic [2:0] CNT_SPUR = 3'd7;

    typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [1:0]         cap_class_q, cap_class_d;
    logic               cap_ns_q, cap_ns_d;
    logic               cap_to_q, cap_to_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q [8];
    logic [CNT_W-1:0]   cnt_d [8];
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_data_q, cnt_data_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head;
    logic               push, pop, res_valid, slot_free;

    assign res_valid = (count_q != '0);
    assign push      = (state_q == CAPTURE);
    assign pop       = res_valid && res.res_ready;
    // A pop in the same cycle frees the slot the next inference will need.
    assign slot_free = (count_q != FULL_N) || pop;
    assign head      = mem_q[rd_ptr_q];

    assign start_process    = (state_q == START);
    assign busy             = busy_q;
    assign err_spurious     = err_q;
    assign cnt_data         = cnt_data_q;
    assign res.res_valid    = res_valid;
    assign res.res_class    = res_valid ? head[CNT_W+3:CNT_W+2] : 2'd0;
    assign res.res_no_spike = res_valid ? head[CNT_W+1] : 1'b0;
    assign res.res_timeout  = res_valid ? head[CNT_W] : 1'b0;
    assign res.res_index    = res_valid ? head[CNT_W-1:0] : '0;

    // Inference sequencer: launch, wait with watchdog, capture result.
    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        cap_class_d = cap_class_q;
        cap_ns_d    = cap_ns_q;
        cap_to_d    = cap_to_q;
        case (state_q)
            IDLE:    if (enable && slot_free) state_d = START;
            START: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wdog_d = wdog_q + WD_W'(1);
                if (end_process) begin
                    cap_class_d = output_class;
                    cap_ns_d    = no_spike;
                    cap_to_d    = 1'b0;
                    state_d     = CAPTURE;
                end else if (wdog_q == WD_LAST) begin
                    cap_class_d = 2'd0;
                    cap_ns_d    = 1'b1;
                    cap_to_d    = 1'b1;
                    state_d     = CAPTURE;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Histogram counters, sticky spurious flag and result index; clear wins.
    always_comb begin
        for (int i = 0; i < 8; i++) cnt_d[i] = cnt_q[i];
        err_d = err_q;
        idx_d = idx_q;
        if (push) begin
            idx_d          = idx_q + CNT_W'(1);
            cnt_d[CNT_TOT] = sat_inc(cnt_q[CNT_TOT]);
            if (cap_to_q) begin
                cnt_d[CNT_TO] = sat_inc(cnt_q[CNT_TO]);
            end else begin
                cnt_d[{1'b0, cap_class_q}] = sat_inc(cnt_q[{1'b0, cap_class_q}]);
                if (cap_ns_q) cnt_d[CNT_NS] = sat_inc(cnt_q[CNT_NS]);
            end
        end
        if (end_process && (state_q != WAIT)) begin
            err_d           = 1'b1;
            cnt_d[CNT_SPUR] = sat_inc(cnt_q[CNT_SPUR]);
        end
        if (cnt_clear) begin
            for (int i = 0; i < 8; i++) cnt_d[i] = '0;
            err_d = 1'b0;
            idx_d = '0;
        end
        cnt_data_d = cnt_q[cnt_sel];
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
        else if (!push && pop) count_d = count_q - (PTR_W + 1)'(1);
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            wdog_q     <= '0;
            idx_q      <= '0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            cnt_data_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            idx_q      <= idx_d;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
            err_q      <= err_d;
            busy_q     <= busy_d;
            cnt_data_q <= cnt_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Captured result and FIFO storage; outputs are masked while empty.
    always_ff @(posedge clk) begin
        cap_class_q <= cap_class_d;
        cap_ns_q    <= cap_ns_d;
        cap_to_q    <= cap_to_d;
        if (push) mem_q[wr_ptr_q] <= {cap_class_q, cap_ns_q, cap_to_q, idx_q};
    end
endmodule
